uart_tx_arbiter: RTL and testbench
==================================

# uart_tx_arbiter

Round-robin arbiter that shares one `uart_tx` transmitter between `N_REQ` byte-stream requesters (e.g. camera status, debug console, command echo). It accepts bytes over a valid/ready handshake and drives the transmitter's `data_tx`/`valid`/`tx_ready` interface. It locks the grant to one requester until that requester's `last` byte, so multi-byte packets are never interleaved. A lock timeout releases a stalled owner.

## Interface
- `N_REQ`, 4: number of requesters, range 2..8.
- `BITS_N`, 8: data bits per byte; matches `uart_tx` `BITS_N`.
- `LOCK_TIMEOUT`, 1024: consecutive idle cycles of a locked owner before the lock is forcibly released; must be ≥1.
- `clk` in 1: single system clock; all logic on its rising edge.
- `reset` in 1: synchronous, active-low reset.
- `req_valid` in N_REQ: bit i means requester i presents a byte.
- `req_data` in N_REQ*BITS_N: byte of requester i on bits [i*BITS_N +: BITS_N].
- `req_last` in N_REQ: bit i means the presented byte ends requester i's packet.
- `req_ready` out N_REQ: one-hot; bit i high means requester i's byte is accepted this cycle.
- `data_tx` out BITS_N: byte to the transmitter; registered, held stable until the next issue.
- `valid` out 1: one-cycle issue strobe to the transmitter.
- `tx_ready` in 1: transmitter idle, from `uart_tx`.
- `grant` out N_REQ: one-hot current lock owner; 0 when no packet is in progress.
- `lock_abort` out 1: one-cycle pulse when the lock is released by timeout.

## Operation
- FSM states:
  - ARB: select a requester, or wait.
  - SEND: `valid` is high.
  - WAIT_LOW: wait for `tx_ready`=0.
  - WAIT_HIGH: wait for `tx_ready`=1.
- Internal registers:
  - `ptr`: last served index.
  - `locked` and `owner`.
  - `idle_cnt`: width clog2(LOCK_TIMEOUT+1).
- ARB, unlocked:
  - Candidates are all i with `req_valid[i]`=1.
  - Winner is the first candidate found scanning ptr+1, ptr+2, … modulo N_REQ.
- ARB, locked: the only candidate is `owner`.
- Accept condition is state ARB, `tx_ready`=1, and a candidate present. On accept (Mealy):
  - `req_ready[winner]`=1 that cycle.
  - At the edge: `data_tx` ← byte of the winner, `valid` ← 1, state ← SEND, `idle_cnt` ← 0.
  - If `req_last[winner]`=1: `locked` ← 0, `grant` ← 0, `ptr` ← winner.
  - Otherwise: `locked` ← 1, `owner` ← winner, `grant` ← onehot(winner).
- SEND lasts exactly one cycle: `valid` ← 0, state ← WAIT_LOW.
- WAIT_LOW: stay until `tx_ready`=0, then go to WAIT_HIGH.
- WAIT_HIGH: stay until `tx_ready`=1, then go to ARB.
- `req_ready` is 0 in all states other than ARB.
- Lock timeout, counted only in ARB with `locked`=1 and `req_valid[owner]`=0:
  - Each such cycle, `idle_cnt` increments.
  - When it reaches LOCK_TIMEOUT: `locked` ← 0, `grant` ← 0, `ptr` ← owner, `idle_cnt` ← 0, and `lock_abort` pulses for one cycle.
  - Arbitration is unlocked from the next cycle.
- `idle_cnt` clears on any owner accept and whenever unlocked.
- Requesters other than the owner are ignored while locked, even if they are valid; they are never granted.
- The requester's handshake contract: `req_data`/`req_last` must be stable while `req_valid`=1 and `req_ready`=0.

## Timing
- Reset (`reset`=0 at a rising edge) is the same whether idle or mid-operation:
  - State ← ARB, `valid`=0, `data_tx`=0, `req_ready`=0, `grant`=0, `lock_abort`=0.
  - `locked`=0, `ptr`=N_REQ-1 (requester 0 has first priority), `idle_cnt`=0.
- Reset mid-frame aborts the lock. If the transmitter is still busy, ARB holds off until `tx_ready`=1.
- Accept at cycle k leads to `valid`=1 in cycle k+1 only.
- `tx_ready` high in WAIT_HIGH at cycle m:
  - State is ARB at m+1.
  - The next accept can happen at m+1.
  - Minimum gap between `valid` pulses is 4 cycles plus the transmitter busy time.
- The transmitter must drop `tx_ready` within a bounded time after `valid`. The arbiter never reissues on a stale `tx_ready`=1 seen in SEND or WAIT_LOW.
- Timeout: owner invalid from the ARB cycle t onward gives `lock_abort` high at t+LOCK_TIMEOUT. Other requesters become eligible at t+LOCK_TIMEOUT+1.
- Simultaneous owner `req_valid` rising on the timeout cycle: the accept wins. The byte is sent, `idle_cnt` ← 0, and there is no abort.
- Single requester with `last` on every byte: grant stays 0 and ptr tracks that requester.

## Test plan
Bench instantiates `uart_tx` with CLKS_PER_BIT=4, N_REQ=4, LOCK_TIMEOUT=16 unless noted.
- Single byte, no contention:
  - Stimulus: req0 sends 8'hA5 with last=1.
  - Required: `req_ready[0]` for one cycle, `valid` one cycle later with `data_tx`=8'hA5, serial line decodes 0xA5, `grant` stays 0.
- Round robin:
  - Stimulus: all four requesters hold single-byte packets 8'h10..8'h13 continuously.
  - Required: transmit order is 0,1,2,3,0,1… and no requester is served twice in a row.
- Packet lock:
  - Stimulus: req2 sends 3 bytes 8'h01,8'h02,8'h03 (last on the third) while req0/req1 are valid.
  - Required: `grant`=4'b0100 during the packet, the line carries 01,02,03 contiguously, then req3… rotation resumes from index 3.
- Lock timeout:
  - Stimulus: req1 sends a non-last byte, then drops `req_valid`; req0 stays valid.
  - Required: `lock_abort` pulses exactly 16 ARB cycles after the transmitter goes idle, then req0 is served and `grant` returns to 0.
- Reset mid-packet:
  - Stimulus: assert `reset`=0 for 1 cycle during the second byte of a locked packet.
  - Required: all outputs are at reset values the next cycle, `grant`=0, and the next accept occurs only after `tx_ready`=1, with requester 0 having priority.
- Handshake stability:
  - Stimulus: the transmitter holds `tx_ready`=0 for 100 cycles after reset.
  - Required: no `req_ready` and no `valid` until `tx_ready` rises, and pending `req_data` is sent unchanged.

Source files
------------

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one uart_tx transmitter between N_REQ byte streams.
// Grant locks to a requester until its last byte; a lock timeout frees a stalled owner.
// Ports:
//   clk, reset       - system clock, synchronous active-low reset
//   req_valid/last   - per-requester byte valid and end-of-packet flags
//   req_data         - per-requester bytes, requester i on [i*BITS_N +: BITS_N]
//   req_ready        - one-hot accept strobe (combinational, ARB state only)
//   data_tx, valid   - registered byte and one-cycle issue strobe to the transmitter
//   tx_ready         - transmitter idle
//   grant            - one-hot lock owner, 0 when no packet is in progress
//   lock_abort       - one-cycle pulse when the lock is released by timeout
module uart_tx_arbiter #(
  parameter int unsigned N_REQ        = 4,
  parameter int unsigned BITS_N       = 8,
  parameter int unsigned LOCK_TIMEOUT = 1024
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic [N_REQ-1:0]          req_valid,
  input  logic [N_REQ*BITS_N-1:0]   req_data,
  input  logic [N_REQ-1:0]          req_last,
  output logic [N_REQ-1:0]          req_ready,
  output logic [BITS_N-1:0]         data_tx,
  output logic                      valid,
  input  logic                      tx_ready,
  output logic [N_REQ-1:0]          grant,
  output logic                      lock_abort
);

  localparam int unsigned IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;
  localparam int unsigned CNT_W = $clog2(LOCK_TIMEOUT + 1);
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(LOCK_TIMEOUT);

  typedef enum logic [1:0] {
    ARB       = 2'd0,
    SEND      = 2'd1,
    WAIT_LOW  = 2'd2,
    WAIT_HIGH = 2'd3
  } state_t;

  state_t             state, state_nx;
  logic [IDX_W-1:0]   ptr, ptr_nx;
  logic               locked, locked_nx;
  logic [IDX_W-1:0]   owner, owner_nx;
  logic [CNT_W-1:0]   idle_cnt, idle_cnt_nx;
  logic [N_REQ-1:0]   grant_nx;
  logic [BITS_N-1:0]  data_nx;
  logic               valid_nx;

  logic               found;
  logic [IDX_W-1:0]   winner;
  logic [IDX_W-1:0]   cand;
  logic [N_REQ-1:0]   win_oh;

  // Candidate selection: the owner alone while locked, else first valid after ptr.
  always_comb begin
    found  = 1'b0;
    winner = owner;
    cand   = '0;
    if (locked) begin
      found = req_valid[owner];
    end else begin
      for (int unsigned k = 1; k <= N_REQ; k++) begin
        cand = IDX_W'((32'(ptr) + k) % N_REQ);
        if (!found && req_valid[cand]) begin
          found  = 1'b1;
          winner = cand;
        end
      end
    end
    win_oh = N_REQ'(1) << winner;
  end

  // Next-state, lock bookkeeping and Mealy handshake outputs.
  always_comb begin
    state_nx    = state;
    ptr_nx      = ptr;
    locked_nx   = locked;
    owner_nx    = owner;
    idle_cnt_nx = idle_cnt;
    grant_nx    = grant;
    data_nx     = data_tx;
    valid_nx    = 1'b0;
    req_ready   = '0;
    lock_abort  = 1'b0;

    case (state)
      ARB: begin
        if (tx_ready && found) begin
          req_ready   = win_oh;
          data_nx     = req_data[32'(winner)*BITS_N +: BITS_N];
          valid_nx    = 1'b1;
          state_nx    = SEND;
          idle_cnt_nx = '0;
          if (req_last[winner]) begin
            locked_nx = 1'b0;
            grant_nx  = '0;
            ptr_nx    = winner;
          end else begin
            locked_nx = 1'b1;
            owner_nx  = winner;
            grant_nx  = win_oh;
          end
        end else if (locked && !req_valid[owner]) begin
          // An owner accept on the same cycle takes the branch above and wins.
          if (idle_cnt >= CNT_MAX) begin
            lock_abort  = 1'b1;
            locked_nx   = 1'b0;
            grant_nx    = '0;
            ptr_nx      = owner;
            idle_cnt_nx = '0;
          end else begin
            idle_cnt_nx = idle_cnt + CNT_W'(1);
          end
        end
      end
      SEND:      state_nx = WAIT_LOW;
      // Ignore a stale tx_ready=1 until the transmitter has visibly gone busy.
      WAIT_LOW:  if (!tx_ready) state_nx = WAIT_HIGH;
      WAIT_HIGH: if (tx_ready)  state_nx = ARB;
      default:   state_nx = ARB;
    endcase

    if (!reset) begin
      req_ready  = '0;
      lock_abort = 1'b0;
    end
  end

  // State and output registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state    <= ARB;
      ptr      <= IDX_W'(N_REQ - 1);
      locked   <= 1'b0;
      owner    <= '0;
      idle_cnt <= '0;
      grant    <= '0;
      data_tx  <= '0;
      valid    <= 1'b0;
    end else begin
      state    <= state_nx;
      ptr      <= ptr_nx;
      locked   <= locked_nx;
      owner    <= owner_nx;
      idle_cnt <= idle_cnt_nx;
      grant    <= grant_nx;
      data_tx  <= data_nx;
      valid    <= valid_nx;
    end
  end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: behavioural transmitter with serial line and
// receiver, queued requesters, a transaction-level reference model checked
// every cycle, and directed scenarios with literal expectations.
module tb_uart_tx_arbiter;
  localparam int unsigned N   = 4;
  localparam int unsigned W   = 8;
  localparam int unsigned TO  = 16;
  localparam int unsigned CPB = 4;

  typedef struct packed { logic [W-1:0] d; logic l; } ent_t;

  logic           clk = 1'b0;
  logic           reset = 1'b0;
  logic [N-1:0]   req_valid = '0;
  logic [N-1:0]   req_last = '0;
  logic [N*W-1:0] req_data = '0;
  logic [N-1:0]   req_ready, grant;
  logic [W-1:0]   data_tx;
  logic           valid, lock_abort;
  logic           tx_ready = 1'b1;

  uart_tx_arbiter #(.N_REQ(N), .BITS_N(W), .LOCK_TIMEOUT(TO)) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_last(req_last), .req_ready(req_ready), .data_tx(data_tx),
    .valid(valid), .tx_ready(tx_ready), .grant(grant), .lock_abort(lock_abort)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // Requesters: each presents the head of its queue, popping it once accepted.
  ent_t         pq [N][$];
  logic [N-1:0] acc_s = '0;

  always @(posedge clk) begin
    logic [N-1:0] acc;
    acc = acc_s;
    #1;
    for (int i = 0; i < int'(N); i++) begin
      if (acc[i] && pq[i].size() > 0) void'(pq[i].pop_front());
      if (pq[i].size() > 0) begin
        req_valid[i]         = 1'b1;
        req_data[i*W +: W]   = pq[i][0].d;
        req_last[i]          = pq[i][0].l;
      end else begin
        req_valid[i]         = 1'b0;
        req_data[i*W +: W]   = '0;
        req_last[i]          = 1'b0;
      end
    end
  end

  // Transmitter: 8N1 frame, CPB clocks per bit, busy while shifting.
  int         hold_cnt = 0;
  int         tx_bits = 0;
  int         tx_tick = 0;
  logic [9:0] tx_sh = '1;
  logic       line = 1'b1;

  always @(posedge clk) begin
    logic         v;
    logic [W-1:0] d;
    v = valid;
    d = data_tx;
    #1;
    if (tx_bits > 0) begin
      tx_tick++;
      if (tx_tick == int'(CPB)) begin
        tx_tick = 0;
        tx_bits--;
        tx_sh = {1'b1, tx_sh[9:1]};
        line  = (tx_bits == 0) ? 1'b1 : tx_sh[0];
      end
      tx_ready = (tx_bits == 0) && (hold_cnt == 0);
    end else if (v) begin
      tx_sh    = {1'b1, d, 1'b0};
      line     = 1'b0;
      tx_bits  = 10;
      tx_tick  = 0;
      tx_ready = 1'b0;
    end else if (hold_cnt > 0) begin
      hold_cnt--;
      tx_ready = 1'b0;
    end else begin
      tx_ready = 1'b1;
    end
  end

  // Serial receiver: bytes actually carried by the line.
  logic [W-1:0] rx_q [$];
  initial begin
    logic [W-1:0] b;
    b = '0;
    forever begin
      @(negedge line);
      repeat (CPB/2) @(posedge clk);
      for (int i = 0; i < int'(W); i++) begin
        repeat (CPB) @(posedge clk);
        b[i] = line;
      end
      repeat (CPB) @(posedge clk);
      rx_q.push_back(b);
    end
  end

  // Reference model: transfer in flight, lock owner (-1 = none), last served, idle run.
  int           m_owner = -1;
  int           m_last = int'(N) - 1;
  int           m_idle = 0;
  bit           m_issue = 1'b0, m_drop = 1'b0, m_rise = 1'b0;
  logic [W-1:0] m_data = '0;
  int           served_q [$];
  bit           mon_on = 1'b0;

  function automatic int rr_pick(input logic [N-1:0] v, input int last);
    for (int k = 1; k <= int'(N); k++)
      if (v[(last + k) % int'(N)]) return (last + k) % int'(N);
    return -1;
  endfunction

  always @(negedge clk) begin
    int           w;
    bit           free, tmo;
    logic [N-1:0] e_rdy;
    w    = -1;
    free = !m_issue && !m_drop && !m_rise;
    if (reset && free && tx_ready)
      w = (m_owner >= 0) ? (req_valid[m_owner] ? m_owner : -1) : rr_pick(req_valid, m_last);
    tmo   = reset && free && (w < 0) && (m_owner >= 0) && !req_valid[m_owner] && (m_idle >= int'(TO));
    e_rdy = (w >= 0) ? (N'(1) << w) : '0;
    acc_s = req_valid & req_ready;
    if (mon_on) begin
      chk("req_ready", 32'(req_ready), 32'(e_rdy));
      chk("valid", 32'(valid), 32'(m_issue));
      chk("data_tx", 32'(data_tx), 32'(m_data));
      chk("grant", 32'(grant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
      chk("lock_abort", 32'(lock_abort), 32'(tmo));
    end
    if (!reset) begin
      m_owner = -1; m_last = int'(N) - 1; m_idle = 0;
      m_issue = 1'b0; m_drop = 1'b0; m_rise = 1'b0; m_data = '0;
    end else if (m_issue) begin
      m_issue = 1'b0; m_drop = 1'b1;
    end else if (m_drop) begin
      if (!tx_ready) begin m_drop = 1'b0; m_rise = 1'b1; end
    end else if (m_rise) begin
      if (tx_ready) m_rise = 1'b0;
    end else if (w >= 0) begin
      m_issue = 1'b1;
      m_data  = req_data[w*W +: W];
      m_idle  = 0;
      served_q.push_back(w);
      if (req_last[w]) begin m_owner = -1; m_last = w; end
      else m_owner = w;
    end else if (m_owner >= 0 && !req_valid[m_owner]) begin
      if (tmo) begin m_last = m_owner; m_owner = -1; m_idle = 0; end
      else m_idle++;
    end
  end

  task automatic push(input int i, input logic [W-1:0] d, input logic l);
    ent_t e;
    e.d = d;
    e.l = l;
    pq[i].push_back(e);
  endtask

  task automatic do_reset();
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    rx_q.delete();
    served_q.delete();
  endtask

  task automatic wait_served(input int n, input string name);
    int k = 0;
    while (served_q.size() < n && k < 2000) begin @(negedge clk); k++; end
    chk(name, 32'(served_q.size() >= n), 32'd1);
  endtask

  task automatic wait_rx(input int n, input string name);
    int k = 0;
    while (rx_q.size() < n && k < 4000) begin @(negedge clk); k++; end
    chk(name, 32'(rx_q.size() >= n), 32'd1);
  endtask

  task automatic wait_tx(input logic lvl, input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (tx_ready != lvl && k < 500);
    chk(name, 32'(tx_ready), 32'(lvl));
  endtask

  task automatic wait_rdy(input string name);
    int k = 0;
    do begin @(negedge clk); k++; end while (req_ready == '0 && k < 500);
    chk(name, 32'(req_ready != '0), 32'd1);
  endtask

  initial begin
    logic [W-1:0] exp3 [6];
    int           ord3 [6];
    int           k;
    exp3 = '{8'h01, 8'h02, 8'h03, 8'h13, 8'h10, 8'h11};
    ord3 = '{2, 2, 2, 3, 0, 1};

    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
    mon_on = 1'b1;
    @(negedge clk);
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_grant", 32'(grant), 32'd0);
    chk("rst_data", 32'(data_tx), 32'd0);

    // Single byte, no contention
    push(0, 8'hA5, 1'b1);
    wait_rdy("t1_wait_rdy");
    chk("t1_ready", 32'(req_ready), 32'h1);
    @(negedge clk);
    chk("t1_valid", 32'(valid), 32'd1);
    chk("t1_data", 32'(data_tx), 32'hA5);
    chk("t1_grant", 32'(grant), 32'd0);
    chk("t1_ready_once", 32'(req_ready), 32'd0);
    @(negedge clk);
    chk("t1_valid_once", 32'(valid), 32'd0);
    wait_rx(1, "t1_wait_rx");
    chk("t1_line", 32'(rx_q[0]), 32'hA5);

    // Round robin with all requesters continuously valid
    do_reset();
    for (int r = 0; r < 3; r++)
      for (int i = 0; i < int'(N); i++) push(i, W'(8'h10 + i), 1'b1);
    wait_rx(12, "t2_wait_rx");
    for (int j = 0; j < 12; j++) begin
      chk("t2_order", 32'(served_q[j]), 32'(j % 4));
      chk("t2_line", 32'(rx_q[j]), 32'(8'h10 + (j % 4)));
    end

    // Packet lock on requester 2, then rotation resumes from 3
    do_reset();
    push(2, 8'h01, 1'b0); push(2, 8'h02, 1'b0); push(2, 8'h03, 1'b1);
    wait_served(1, "t3_wait_first");
    @(negedge clk);
    chk("t3_grant", 32'(grant), 32'h4);
    push(0, 8'h10, 1'b1); push(1, 8'h11, 1'b1); push(3, 8'h13, 1'b1);
    wait_rx(6, "t3_wait_rx");
    for (int j = 0; j < 6; j++) begin
      chk("t3_order", 32'(served_q[j]), 32'(ord3[j]));
      chk("t3_line", 32'(rx_q[j]), 32'(exp3[j]));
    end

    // Lock timeout on a stalled owner
    do_reset();
    push(1, 8'h55, 1'b0);
    wait_served(1, "t4_wait_first");
    push(0, 8'h66, 1'b1);
    wait_tx(1'b0, "t4_tx_busy");
    wait_tx(1'b1, "t4_tx_idle");
    chk("t4_grant_locked", 32'(grant), 32'h2);
    k = 0;
    do begin @(negedge clk); k++; end while (!lock_abort && k < 40);
    chk("t4_abort_cycle", 32'(k), 32'd17);
    chk("t4_grant_at_abort", 32'(grant), 32'h2);
    @(negedge clk);
    chk("t4_ready_req0", 32'(req_ready), 32'h1);
    chk("t4_abort_pulse", 32'(lock_abort), 32'd0);
    @(negedge clk);
    chk("t4_grant_free", 32'(grant), 32'd0);
    chk("t4_valid", 32'(valid), 32'd1);
    chk("t4_data", 32'(data_tx), 32'h66);
    wait_rx(2, "t4_wait_rx");
    chk("t4_line0", 32'(rx_q[0]), 32'h55);
    chk("t4_line1", 32'(rx_q[1]), 32'h66);

    // Reset during the second byte of a locked packet
    do_reset();
    push(3, 8'hA1, 1'b0); push(3, 8'hA2, 1'b0); push(3, 8'hA3, 1'b1);
    wait_served(2, "t5_wait_second");
    push(0, 8'hB0, 1'b1);
    wait_tx(1'b0, "t5_tx_busy");
    repeat (5) @(negedge clk);
    @(posedge clk); #1 reset = 1'b0;
    @(posedge clk); #1 reset = 1'b1;
    @(negedge clk);
    chk("t5_valid", 32'(valid), 32'd0);
    chk("t5_data", 32'(data_tx), 32'd0);
    chk("t5_grant", 32'(grant), 32'd0);
    chk("t5_ready", 32'(req_ready), 32'd0);
    chk("t5_abort", 32'(lock_abort), 32'd0);
    wait_rdy("t5_wait_rdy");
    chk("t5_tx_idle", 32'(tx_ready), 32'd1);
    chk("t5_prio0", 32'(req_ready), 32'h1);
    wait_rx(4, "t5_wait_rx");
    chk("t5_line2", 32'(rx_q[2]), 32'hB0);
    chk("t5_line3", 32'(rx_q[3]), 32'hA3);

    // Transmitter held busy after reset
    hold_cnt = 100;
    do_reset();
    push(2, 8'h3C, 1'b1);
    for (int j = 0; j < 90; j++) begin
      @(negedge clk);
      chk("t6_no_ready", 32'(req_ready), 32'd0);
      chk("t6_no_valid", 32'(valid), 32'd0);
    end
    wait_rx(1, "t6_wait_rx");
    chk("t6_line", 32'(rx_q[0]), 32'h3C);

    repeat (5) @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
